adbg_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP controller that sits directly upstream of the debug top level.
- Decodes TMS into the 16-state TAP FSM and holds the instruction register (IR), the IDCODE register and the BYPASS register.
- Drives shift/pause/update/capture DR strobes and the debug instruction select into the debug top.
- Muxes the debug top's TDO onto the chip TDO pin.

---
 rtl/adbg_tap_pkg.sv | 40 ++++
 rtl/adbg_tap_fsm.sv | 42 ++++
 rtl/adbg_tap_ctrl.sv | 136 +++++++++++++
 tb/tb_adbg_tap_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_tap_pkg.sv
// Shared definitions for the debug TAP controller: state encoding, default opcodes and IR capture.
package adbg_tap_pkg;

  localparam int unsigned IrLen = 4;

  localparam logic [31:0]      IdcodeValue  = 32'h149511C3;
  localparam logic [IrLen-1:0] IdcodeOpcode = 4'h2;
  localparam logic [IrLen-1:0] DebugOpcode  = 4'h8;
  localparam logic [IrLen-1:0] BypassOpcode = 4'hF;

  // The two IR LSBs must capture as 01; the upper bits capture as zero.
  localparam logic [1:0]       IrCaptureLsbs = 2'b01;
  localparam logic [IrLen-1:0] IrCapture     = IrLen'(IrCaptureLsbs);

  // Classic 1149.1 reference encoding of the 16 TAP states.
  typedef enum logic [3:0] {
    StExit2Dr        = 4'h0,
    StExit1Dr        = 4'h1,
    StShiftDr        = 4'h2,
    StPauseDr        = 4'h3,
    StSelectIrScan   = 4'h4,
    StUpdateDr       = 4'h5,
    StCaptureDr      = 4'h6,
    StSelectDrScan   = 4'h7,
    StExit2Ir        = 4'h8,
    StExit1Ir        = 4'h9,
    StShiftIr        = 4'hA,
    StPauseIr        = 4'hB,
    StRunTestIdle    = 4'hC,
    StUpdateIr       = 4'hD,
    StCaptureIr      = 4'hE,
    StTestLogicReset = 4'hF
  } tap_state_t;

  // True in either shift state; TDO is driven only there.
  function automatic logic is_shift_state(tap_state_t st);
    return (st == StShiftDr) || (st == StShiftIr);
  endfunction

endpackage

// File: rtl/adbg_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine, advanced by TMS on the rising edge of TCK.
module adbg_tap_fsm
  import adbg_tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       rst_i,
  input  logic       tms_i,
  output tap_state_t state_o
);

  tap_state_t state_q;

  // TAP state register; async reset lands in TEST_LOGIC_RESET regardless of TCK.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StTestLogicReset;
    end else begin
      unique case (state_q)
        StTestLogicReset: state_q <= tms_i ? StTestLogicReset : StRunTestIdle;
        StRunTestIdle:    state_q <= tms_i ? StSelectDrScan   : StRunTestIdle;
        StSelectDrScan:   state_q <= tms_i ? StSelectIrScan   : StCaptureDr;
        StCaptureDr:      state_q <= tms_i ? StExit1Dr        : StShiftDr;
        StShiftDr:        state_q <= tms_i ? StExit1Dr        : StShiftDr;
        StExit1Dr:        state_q <= tms_i ? StUpdateDr       : StPauseDr;
        StPauseDr:        state_q <= tms_i ? StExit2Dr        : StPauseDr;
        StExit2Dr:        state_q <= tms_i ? StUpdateDr       : StShiftDr;
        StUpdateDr:       state_q <= tms_i ? StSelectDrScan   : StRunTestIdle;
        StSelectIrScan:   state_q <= tms_i ? StTestLogicReset : StCaptureIr;
        StCaptureIr:      state_q <= tms_i ? StExit1Ir        : StShiftIr;
        StShiftIr:        state_q <= tms_i ? StExit1Ir        : StShiftIr;
        StExit1Ir:        state_q <= tms_i ? StUpdateIr       : StPauseIr;
        StPauseIr:        state_q <= tms_i ? StExit2Ir        : StPauseIr;
        StExit2Ir:        state_q <= tms_i ? StUpdateIr       : StShiftIr;
        StUpdateIr:       state_q <= tms_i ? StSelectDrScan   : StRunTestIdle;
        default:          state_q <= StTestLogicReset;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/adbg_tap_ctrl.sv
// JTAG TAP controller in front of the debug top: FSM, IR, IDCODE/BYPASS DRs and the TDO mux.
module adbg_tap_ctrl
  import adbg_tap_pkg::*;
#(
  parameter int unsigned        IR_LEN        = IrLen,
  parameter logic [31:0]        IDCODE_VALUE  = IdcodeValue,
  parameter logic [IR_LEN-1:0]  IDCODE_OPCODE = IdcodeOpcode,
  parameter logic [IR_LEN-1:0]  DEBUG_OPCODE  = DebugOpcode,
  parameter logic [IR_LEN-1:0]  BYPASS_OPCODE = BypassOpcode
) (
  input  logic tck_i,
  input  logic rst_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tdo_o,
  output logic tdo_oe_o,
  input  logic debug_tdo_i,
  output logic test_logic_reset_o,
  output logic run_test_idle_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic debug_select_o
);

  localparam logic [IR_LEN-1:0] IrCapturePattern = IR_LEN'(IrCaptureLsbs);

  tap_state_t        state;
  logic [IR_LEN-1:0] ir_shift_q;
  logic [IR_LEN-1:0] ir_latched_q;
  logic [31:0]       idcode_q;
  logic              bypass_q;
  logic              tdo_q;
  logic              tdo_oe_q;

  logic sel_idcode;
  logic sel_debug;
  logic sel_bypass;
  logic dr_tdo;

  adbg_tap_fsm u_fsm (
    .tck_i   (tck_i),
    .rst_i   (rst_i),
    .tms_i   (tms_i),
    .state_o (state)
  );

  // Instruction decode; anything not IDCODE or DEBUG falls back to BYPASS.
  assign sel_idcode = (ir_latched_q == IDCODE_OPCODE);
  assign sel_debug  = !sel_idcode && (ir_latched_q == DEBUG_OPCODE);
  assign sel_bypass = !sel_idcode && !sel_debug &&
                      ((ir_latched_q == BYPASS_OPCODE) || (ir_latched_q != BYPASS_OPCODE));

  // IR shift stage: capture the fixed pattern, then shift LSB first towards TDO.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      ir_shift_q <= '0;
    end else if (state == StCaptureIr) begin
      ir_shift_q <= IrCapturePattern;
    end else if (state == StShiftIr) begin
      ir_shift_q <= {tdi_i, ir_shift_q[IR_LEN-1:1]};
    end
  end

  // Active instruction; only UPDATE_IR, TLR or reset may change it.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      ir_latched_q <= IDCODE_OPCODE;
    end else if (state == StTestLogicReset) begin
      ir_latched_q <= IDCODE_OPCODE;
    end else if (state == StUpdateIr) begin
      ir_latched_q <= ir_shift_q;
    end
  end

  // IDCODE data register, active only while IDCODE is the selected instruction.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      idcode_q <= '0;
    end else if (sel_idcode && (state == StCaptureDr)) begin
      idcode_q <= IDCODE_VALUE;
    end else if (sel_idcode && (state == StShiftDr)) begin
      idcode_q <= {tdi_i, idcode_q[31:1]};
    end
  end

  // One-bit BYPASS register: captures 0, then delays TDI by one TCK.
  always_ff @(posedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      bypass_q <= 1'b0;
    end else if (sel_bypass && (state == StCaptureDr)) begin
      bypass_q <= 1'b0;
    end else if (sel_bypass && (state == StShiftDr)) begin
      bypass_q <= tdi_i;
    end
  end

  // DR source for TDO; the debug top owns the chain when debug is selected.
  always_comb begin
    dr_tdo = bypass_q;
    if (sel_debug) begin
      dr_tdo = debug_tdo_i;
    end else if (sel_idcode) begin
      dr_tdo = idcode_q[0];
    end
  end

  // TDO launched on the falling edge so the far end samples it cleanly on the next rise.
  always_ff @(negedge tck_i or posedge rst_i) begin
    if (rst_i) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_oe_q <= is_shift_state(state);
      if (state == StShiftIr) begin
        tdo_q <= ir_shift_q[0];
      end else if (state == StShiftDr) begin
        tdo_q <= dr_tdo;
      end
    end
  end

  assign tdo_o    = tdo_q;
  assign tdo_oe_o = tdo_oe_q;

  // State strobes decode the live state so they line up with the downstream capturing edge.
  assign test_logic_reset_o = (state == StTestLogicReset);
  assign run_test_idle_o    = (state == StRunTestIdle);
  assign capture_dr_o       = (state == StCaptureDr);
  assign shift_dr_o         = (state == StShiftDr);
  assign pause_dr_o         = (state == StPauseDr);
  assign update_dr_o        = (state == StUpdateDr);
  assign debug_select_o     = sel_debug;

endmodule

// File: tb/tb_adbg_tap_ctrl.sv
// Self-checking bench for adbg_tap_ctrl against a queue-based scan model.
module tb_adbg_tap_ctrl;

  logic tck = 1'b0;
  logic rst, tms, tdi, debug_tdo;
  logic tdo, tdo_oe, st_tlr, st_rti, st_cdr, st_shdr, st_pdr, st_udr, dbg_sel;
  logic [8:0] act_vec;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  adbg_tap_ctrl dut (
    .tck_i              (tck),
    .rst_i              (rst),
    .tms_i              (tms),
    .tdi_i              (tdi),
    .tdo_o              (tdo),
    .tdo_oe_o           (tdo_oe),
    .debug_tdo_i        (debug_tdo),
    .test_logic_reset_o (st_tlr),
    .run_test_idle_o    (st_rti),
    .capture_dr_o       (st_cdr),
    .shift_dr_o         (st_shdr),
    .pause_dr_o         (st_pdr),
    .update_dr_o        (st_udr),
    .debug_select_o     (dbg_sel)
  );

  assign act_vec = {st_tlr, st_rti, st_cdr, st_shdr, st_pdr, st_udr, dbg_sel, tdo, tdo_oe};

  // Reference model: TAP position by name, scan chains as bit queues (front = next TDO bit).
  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
  localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14;
  localparam int UIR = 15;

  int       m_st;
  bit [3:0] m_ir;
  bit       m_irq[$];
  bit       m_drq[$];
  bit       m_tdo, m_oe;
  bit [31:0] idv = 32'h149511C3;

  function automatic int next_st(int s, bit t);
    case (s)
      TLR:  return t ? TLR  : RTI;
      RTI:  return t ? SDR  : RTI;
      SDR:  return t ? SIR  : CDR;
      CDR:  return t ? E1DR : SHDR;
      SHDR: return t ? E1DR : SHDR;
      E1DR: return t ? UDR  : PDR;
      PDR:  return t ? E2DR : PDR;
      E2DR: return t ? UDR  : SHDR;
      UDR:  return t ? SDR  : RTI;
      SIR:  return t ? TLR  : CIR;
      CIR:  return t ? E1IR : SHIR;
      SHIR: return t ? E1IR : SHIR;
      E1IR: return t ? UIR  : PIR;
      PIR:  return t ? E2IR : PIR;
      E2IR: return t ? UIR  : SHIR;
      UIR:  return t ? SDR  : RTI;
      default: return TLR;
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    return {m_st == TLR, m_st == RTI, m_st == CDR, m_st == SHDR, m_st == PDR, m_st == UDR,
            m_ir == 4'h8, m_tdo, m_oe};
  endfunction

  task automatic model_reset();
    m_st = TLR; m_ir = 4'h2; m_tdo = 1'b0; m_oe = 1'b0;
    m_irq.delete(); m_drq.delete();
  endtask

  task automatic model_posedge(input bit t, input bit d);
    case (m_st)
      TLR: m_ir = 4'h2;
      CIR: begin
        m_irq.delete();
        for (int i = 0; i < 4; i++) m_irq.push_back(i == 0);
      end
      SHIR: begin void'(m_irq.pop_front()); m_irq.push_back(d); end
      UIR: for (int i = 0; i < 4; i++) m_ir[i] = m_irq[i];
      CDR: begin
        if (m_ir == 4'h2) begin
          m_drq.delete();
          for (int i = 0; i < 32; i++) m_drq.push_back(idv[i]);
        end else if (m_ir != 4'h8) begin
          m_drq.delete();
          m_drq.push_back(1'b0);
        end
      end
      SHDR: if (m_ir != 4'h8) begin void'(m_drq.pop_front()); m_drq.push_back(d); end
      default: ;
    endcase
    m_st = next_st(m_st, t);
  endtask

  task automatic model_negedge(input bit dt);
    if (m_st == SHIR) m_tdo = m_irq[0];
    else if (m_st == SHDR) m_tdo = (m_ir == 4'h8) ? dt : m_drq[0];
    m_oe = (m_st == SHIR) || (m_st == SHDR);
  endtask

  // One full TCK: drive, rising edge, falling edge; returns 1 time unit after the fall.
  task automatic cyc(input bit t, input bit d, input bit dt);
    tms = t; tdi = d; debug_tdo = dt;
    @(posedge tck);
    model_posedge(t, d);
    @(negedge tck);
    model_negedge(dt);
    #1;
  endtask

  // Load an instruction starting and ending in RUN_TEST_IDLE.
  task automatic load_ir(input bit [3:0] v);
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(i == 3, v[i], 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0; tms = 1'b1; tdi = 1'b0; debug_tdo = 1'b0;
    #2 rst = 1'b1;
    #1 model_reset();
    checks++;
    if (act_vec !== 9'h100) begin
      errors++; $display("FAIL reset_values got %b want %b", act_vec, 9'h100);
    end
    @(negedge tck); #1 rst = 1'b0;
    cyc(0, 0, 0);
    checks++;
    if (st_rti !== 1'b1 || st_tlr !== 1'b0) begin
      errors++; $display("FAIL rti_after_reset got rti=%b tlr=%b want 1 0", st_rti, st_tlr);
    end
    checks++;
    if ({st_cdr, st_shdr, st_pdr, st_udr, dbg_sel} !== 5'b0) begin
      errors++;
      $display("FAIL strobes_idle got %b want 00000", {st_cdr, st_shdr, st_pdr, st_udr, dbg_sel});
    end
  endtask

  task automatic test_idcode();
    cyc(1, 0, 0); cyc(0, 0, 0);
    checks++;
    if (st_cdr !== 1'b1 || tdo_oe !== 1'b0) begin
      errors++; $display("FAIL idcode_capture got cdr=%b oe=%b want 1 0", st_cdr, tdo_oe);
    end
    cyc(0, $urandom_range(0, 1), 0);
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (tdo !== idv[i] || tdo_oe !== 1'b1) begin
        errors++; $display("FAIL idcode_bit%0d got tdo=%b oe=%b want %b 1", i, tdo, tdo_oe, idv[i]);
      end
      cyc(i == 31, $urandom_range(0, 1), 0);
    end
    checks++;
    if (tdo_oe !== 1'b0) begin
      errors++; $display("FAIL idcode_oe_after got %b want 0", tdo_oe);
    end
    cyc(1, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic test_ir_debug();
    bit [3:0] opc = 4'h8;
    bit [3:0] cap = 4'b0001;
    int n, n_cap, n_sh, n_up;
    bit dt;
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tdo !== cap[i] || tdo_oe !== 1'b1) begin
        errors++; $display("FAIL ir_tdo%0d got tdo=%b oe=%b want %b 1", i, tdo, tdo_oe, cap[i]);
      end
      cyc(i == 3, opc[i], 0);
    end
    cyc(1, 0, 0);
    checks++;
    if (dbg_sel !== 1'b0) begin
      errors++; $display("FAIL ir_not_yet_latched got %b want 0", dbg_sel);
    end
    cyc(0, 0, 0);
    checks++;
    if (dbg_sel !== 1'b1) begin
      errors++; $display("FAIL debug_select got %b want 1", dbg_sel);
    end
    n = $urandom_range(3, 10);
    n_cap = 0; n_sh = 0; n_up = 0;
    for (int k = 0; k < n + 5; k++) begin
      bit t;
      t = (k == 0) || (k == n + 2) || (k == n + 3);
      dt = $urandom_range(0, 1);
      cyc(t, $urandom_range(0, 1), dt);
      n_cap += int'(st_cdr); n_sh += int'(st_shdr); n_up += int'(st_udr);
      if (st_shdr === 1'b1) begin
        checks++;
        if (tdo !== dt) begin
          errors++; $display("FAIL debug_tdo_mirror got %b want %b", tdo, dt);
        end
      end
    end
    checks++;
    if (n_cap != 1 || n_sh != n || n_up != 1) begin
      errors++;
      $display("FAIL debug_strobe_counts got %0d/%0d/%0d want 1/%0d/1", n_cap, n_sh, n_up, n);
    end
    checks++;
    if (dbg_sel !== 1'b1) begin
      errors++; $display("FAIL debug_select_held got %b want 1", dbg_sel);
    end
  endtask

  task automatic test_bypass();
    bit pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    load_ir(4'hF);
    checks++;
    if (dbg_sel !== 1'b0) begin
      errors++; $display("FAIL bypass_select got %b want 0", dbg_sel);
    end
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0);
    checks++;
    if (tdo !== 1'b0 || tdo_oe !== 1'b1) begin
      errors++; $display("FAIL bypass_first got tdo=%b oe=%b want 0 1", tdo, tdo_oe);
    end
    for (int k = 0; k < 3; k++) begin
      cyc(0, pat[k], 0);
      checks++;
      if (tdo !== pat[k]) begin
        errors++; $display("FAIL bypass_bit%0d got %b want %b", k + 1, tdo, pat[k]);
      end
    end
    cyc(1, pat[3], 0); cyc(1, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic test_undef_opcode();
    int n;
    bit d;
    load_ir(4'h5);
    checks++;
    if (dbg_sel !== 1'b0) begin
      errors++; $display("FAIL undef_select got %b want 0", dbg_sel);
    end
    cyc(1, 0, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    checks++;
    if (tdo !== 1'b0) begin
      errors++; $display("FAIL undef_first got %b want 0", tdo);
    end
    n = $urandom_range(4, 12);
    for (int k = 0; k < n; k++) begin
      d = $urandom_range(0, 1);
      cyc(0, d, ~d);
      checks++;
      if (tdo !== d) begin
        errors++; $display("FAIL undef_delay%0d got %b want %b", k, tdo, d);
      end
    end
    cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic test_reset_mid_shift();
    load_ir(4'h8);
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1);
    repeat ($urandom_range(1, 5)) cyc(0, $urandom_range(0, 1), 1);
    #2 rst = 1'b1;
    #1 model_reset();
    checks++;
    if (act_vec !== 9'h100) begin
      errors++; $display("FAIL mid_shift_reset got %b want %b", act_vec, 9'h100);
    end
    @(negedge tck); #1 rst = 1'b0;
    cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      cyc(i == 31, $urandom_range(0, 1), 0);
      checks++;
      if (tdo !== idv[i]) begin
        errors++; $display("FAIL post_reset_idcode%0d got %b want %b", i, tdo, idv[i]);
      end
    end
    cyc(1, 0, 0); cyc(0, 0, 0);
  endtask

  task automatic test_five_tms();
    for (int it = 0; it < 6; it++) begin
      load_ir(4'h8);
      repeat ($urandom_range(0, 15)) begin
        cyc($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        checks++;
        if (act_vec !== exp_vec()) begin
          errors++; $display("FAIL walk got %b want %b", act_vec, exp_vec());
        end
      end
      repeat (5) cyc(1, $urandom_range(0, 1), 0);
      checks++;
      if (st_tlr !== 1'b1 || dbg_sel !== 1'b0) begin
        errors++; $display("FAIL five_tms got tlr=%b sel=%b want 1 0", st_tlr, dbg_sel);
      end
      cyc(0, 0, 0);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d got %b want %b", k, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idcode();
    test_ir_debug();
    repeat (5) cyc(1, 0, 0);
    cyc(0, 0, 0);
    test_bypass();
    test_undef_opcode();
    test_reset_mid_shift();
    test_five_tms();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
